tape_ctrl: RTL and testbench

TAPE_CTRL -- requirements
Module: tape_ctrl

---
 rtl/tape_ctrl_pkg.sv | 21 ++
 rtl/tape_ctrl_if.sv | 24 ++
 rtl/tape_ctrl.sv | 135 +++++++++++++
 tb/tb_tape_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_ctrl_pkg.sv
// Shared widths, opcodes and FSM encodings for the tape controller.
// Optional feature macro: BOUNDS_CHECK_EN (see tape_ctrl.sv).
package tape_ctrl_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_STORE = 3'd5;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_MODIFY = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

endpackage

// File: rtl/tape_ctrl_if.sv
// Command/response handshake bundle for tape_ctrl.
// Master drives commands, slave (the controller) responds.
interface tape_ctrl_if;
  import tape_ctrl_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero
  );

endinterface

// File: rtl/tape_ctrl.sv
// Tape machine controller: pointer, data register and RAM sequencing FSM.
// Define BOUNDS_CHECK_EN to saturate the pointer and flag a sticky err.
module tape_ctrl
  import tape_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  tape_ctrl_if.slave            cmd,
  output logic [ADDR_WIDTH-1:0] ptr,
  output logic                  err,
  output logic                  mem_en,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [DATA_WIDTH-1:0] DAT_ONE = 1;

  logic [2:0]            state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  accept;

`ifdef BOUNDS_CHECK_EN
  logic err_q, err_d;
  logic at_lo, at_hi;
  assign at_lo = (ptr_q == '0);
  assign at_hi = (&ptr_q);
`endif

  assign accept = cmd.cmd_valid && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
`ifdef BOUNDS_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = cmd.cmd_op;
          case (cmd.cmd_op)
            OP_INC, OP_DEC, OP_LOAD: state_d = S_READ;
            OP_STORE: begin
              data_d  = cmd.cmd_data;
              state_d = S_WRITE;
            end
            OP_LEFT: begin
              state_d = S_DONE;
`ifdef BOUNDS_CHECK_EN
              if (at_lo) err_d = 1'b1;
              else       ptr_d = ptr_q - PTR_ONE;
`else
              ptr_d = ptr_q - PTR_ONE;
`endif
            end
            OP_RIGHT: begin
              state_d = S_DONE;
`ifdef BOUNDS_CHECK_EN
              if (at_hi) err_d = 1'b1;
              else       ptr_d = ptr_q + PTR_ONE;
`else
              ptr_d = ptr_q + PTR_ONE;
`endif
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_READ: state_d = S_MODIFY;
      // RAM read data is valid here, one cycle after READ.
      S_MODIFY: begin
        case (op_q)
          OP_INC: begin
            data_d  = mem_rdata + DAT_ONE;
            state_d = S_WRITE;
          end
          OP_DEC: begin
            data_d  = mem_rdata - DAT_ONE;
            state_d = S_WRITE;
          end
          default: begin
            data_d  = mem_rdata;
            state_d = S_DONE;
          end
        endcase
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

`ifdef BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign cmd.rsp_valid = (state_q == S_DONE);
  assign cmd.rsp_data  = data_q;
  assign cmd.rsp_zero  = (data_q == '0);

  assign ptr       = ptr_q;
  assign mem_addr  = ptr_q;
  assign mem_en    = (state_q == S_READ) || (state_q == S_WRITE);
  assign mem_wen   = (state_q == S_WRITE);
  assign mem_wdata = data_q;

endmodule

// File: tb/tb_tape_ctrl.sv
// Self-checking bench for tape_ctrl with a behavioural RAM and tape model.
// Honours BOUNDS_CHECK_EN the same way as the design.
module tb_tape_ctrl;
  import tape_ctrl_pkg::*;

`ifdef BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ONE_D = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tape_ctrl_if c();

  logic [ADDR_WIDTH-1:0] ptr;
  logic                  err;
  logic                  mem_en;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  tape_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (c.slave),
    .ptr      (ptr),
    .err      (err),
    .mem_en   (mem_en),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Registered-read RAM with a preload strobe driven from the bench.
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic ld = 1'b0;
  int   seed = 1;
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DATA_WIDTH'(i * seed + 3);
    end else if (mem_en) begin
      if (mem_wen) ram[mem_addr] <= mem_wdata;
      else         mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model of the tape.
  logic [DATA_WIDTH-1:0] ref_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] m_ptr;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_err;

  int checks = 0;
  int passed = 0;

  task automatic model_apply(input logic [2:0] op,
                             input logic [DATA_WIDTH-1:0] d,
                             output int lat);
    case (op)
      OP_INC: begin
        m_data = ref_mem[m_ptr] + ONE_D;
        ref_mem[m_ptr] = m_data;
        lat = 4;
      end
      OP_DEC: begin
        m_data = ref_mem[m_ptr] - ONE_D;
        ref_mem[m_ptr] = m_data;
        lat = 4;
      end
      OP_LEFT: begin
        lat = 1;
        if (BC && m_ptr == 0) m_err = 1'b1;
        else m_ptr = m_ptr - ONE_A;
      end
      OP_RIGHT: begin
        lat = 1;
        if (BC && m_ptr == '1) m_err = 1'b1;
        else m_ptr = m_ptr + ONE_A;
      end
      OP_LOAD: begin
        m_data = ref_mem[m_ptr];
        lat = 3;
      end
      OP_STORE: begin
        m_data = d;
        ref_mem[m_ptr] = d;
        lat = 2;
      end
      default: lat = 1;
    endcase
  endtask

  task automatic exec(input logic [2:0] op,
                      input logic [DATA_WIDTH-1:0] d,
                      output int lat, output int elat);
    int n;
    n = 0;
    @(negedge clk);
    while (!c.cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    c.cmd_valid = 1'b1;
    c.cmd_op    = op;
    c.cmd_data  = d;
    @(posedge clk); #1;
    c.cmd_valid = 1'b0;
    c.cmd_op    = 3'($urandom);
    c.cmd_data  = DATA_WIDTH'($urandom);
    model_apply(op, d, elat);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (c.rsp_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    c.cmd_valid = 1'b0;
    c.cmd_op    = '0;
    c.cmd_data  = '0;
    seed = $urandom_range(1, 255);
    @(negedge clk);
    rst_n = 1'b0;
    ld = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_WIDTH'(i * seed + 3);
    m_ptr = '0; m_data = '0; m_err = 1'b0;
    @(posedge clk); #1;
    ld = 1'b0;
    @(negedge clk);
    checks++;
    if (c.rsp_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", c.rsp_valid);
    else passed++;
    checks++;
    if (ptr !== '0) $display("FAIL rst_ptr got %h want 0", ptr);
    else passed++;
    checks++;
    if (err !== 1'b0) $display("FAIL rst_err got %b want 0", err);
    else passed++;
    checks++;
    if (c.rsp_data !== '0) $display("FAIL rst_data got %h want 0", c.rsp_data);
    else passed++;
    checks++;
    if ({mem_en, mem_wen} !== 2'b00)
      $display("FAIL rst_mem got en=%b wen=%b want 0 0", mem_en, mem_wen);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (c.cmd_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", c.cmd_ready);
    else passed++;
  endtask

  task automatic test_store_load();
    int lat, elat;
    exec(OP_STORE, 8'h2A, lat, elat);
    checks++;
    if (lat !== 2) $display("FAIL store_lat got %0d want 2", lat);
    else passed++;
    exec(OP_LOAD, 8'h00, lat, elat);
    checks++;
    if (lat !== 3) $display("FAIL load_lat got %0d want 3", lat);
    else passed++;
    checks++;
    if (c.rsp_data !== 8'h2A) $display("FAIL load_data got %h want 2a", c.rsp_data);
    else passed++;
    checks++;
    if (c.rsp_zero !== 1'b0) $display("FAIL load_zero got %b want 0", c.rsp_zero);
    else passed++;
    checks++;
    if (ram[0] !== 8'h2A) $display("FAIL load_ram0 got %h want 2a", ram[0]);
    else passed++;
  endtask

  task automatic test_inc_wrap();
    int lat, elat;
    exec(OP_STORE, 8'hFF, lat, elat);
    exec(OP_INC, 8'h00, lat, elat);
    checks++;
    if (lat !== 4) $display("FAIL inc_lat got %0d want 4", lat);
    else passed++;
    checks++;
    if (c.rsp_data !== 8'h00) $display("FAIL inc_data got %h want 00", c.rsp_data);
    else passed++;
    checks++;
    if (c.rsp_zero !== 1'b1) $display("FAIL inc_zero got %b want 1", c.rsp_zero);
    else passed++;
    checks++;
    if (ram[0] !== 8'h00) $display("FAIL inc_ram0 got %h want 00", ram[0]);
    else passed++;
    exec(OP_DEC, 8'h00, lat, elat);
    checks++;
    if (c.rsp_data !== 8'hFF) $display("FAIL dec_data got %h want ff", c.rsp_data);
    else passed++;
    checks++;
    if (ram[0] !== 8'hFF) $display("FAIL dec_ram0 got %h want ff", ram[0]);
    else passed++;
  endtask

  task automatic test_move();
    int lat, elat;
    for (int i = 0; i < 3; i++) exec(OP_RIGHT, 8'h00, lat, elat);
    checks++;
    if (lat !== 1 || ptr !== 8'd3)
      $display("FAIL right_ptr got lat=%0d ptr=%h want 1 03", lat, ptr);
    else passed++;
    exec(OP_STORE, 8'h05, lat, elat);
    for (int i = 0; i < 3; i++) exec(OP_LEFT, 8'h00, lat, elat);
    exec(OP_LOAD, 8'h00, lat, elat);
    checks++;
    if (ptr !== 8'd0) $display("FAIL move_ptr got %h want 00", ptr);
    else passed++;
    checks++;
    if (c.rsp_data !== ref_mem[0])
      $display("FAIL move_data got %h want %h", c.rsp_data, ref_mem[0]);
    else passed++;
    checks++;
    if (ram[3] !== 8'h05) $display("FAIL move_ram3 got %h want 05", ram[3]);
    else passed++;
  endtask

  task automatic test_bounds();
    int lat, elat;
    logic [ADDR_WIDTH-1:0] exp_p;
    exec(OP_LEFT, 8'h00, lat, elat);
    exp_p = BC ? 8'h00 : 8'hFF;
    checks++;
    if (ptr !== exp_p || err !== BC || lat !== 1)
      $display("FAIL left0 got ptr=%h err=%b lat=%0d want %h %b 1",
               ptr, err, lat, exp_p, BC);
    else passed++;
    exec(3'd6, 8'h00, lat, elat);
    checks++;
    if (err !== BC) $display("FAIL err_sticky got %b want %b", err, BC);
    else passed++;
    while (m_ptr != '1) exec(OP_RIGHT, 8'h00, lat, elat);
    exec(OP_RIGHT, 8'h00, lat, elat);
    exp_p = BC ? 8'hFF : 8'h00;
    checks++;
    if (ptr !== exp_p || err !== BC || lat !== 1)
      $display("FAIL rightmax got ptr=%h err=%b lat=%0d want %h %b 1",
               ptr, err, lat, exp_p, BC);
    else passed++;
    test_reset();
  endtask

  task automatic test_reset_mid();
    int lat, elat;
    bit seen;
    exec(OP_STORE, 8'h10, lat, elat);
    @(negedge clk);
    @(negedge clk);
    c.cmd_valid = 1'b1;
    c.cmd_op    = OP_INC;
    @(posedge clk); #1;
    c.cmd_valid = 1'b0;
    checks++;
    if (mem_en !== 1'b1) $display("FAIL mid_read got en=%b want 1", mem_en);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    m_ptr = '0; m_data = '0; m_err = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (c.rsp_valid || mem_wen) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL mid_abort got rsp/write=1 want 0");
    else passed++;
    checks++;
    if (ram[0] !== 8'h10) $display("FAIL mid_ram0 got %h want 10", ram[0]);
    else passed++;
    checks++;
    if (ptr !== '0 || c.rsp_data !== '0)
      $display("FAIL mid_state got ptr=%h data=%h want 00 00", ptr, c.rsp_data);
    else passed++;
  endtask

  task automatic test_random();
    int lat, elat;
    logic [2:0] op;
    logic [DATA_WIDTH-1:0] d;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom);
      d  = DATA_WIDTH'($urandom);
      exec(op, d, lat, elat);
      checks++;
      if (lat !== elat) $display("FAIL rnd_lat op=%0d got %0d want %0d", op, lat, elat);
      else passed++;
      checks++;
      if (c.rsp_data !== m_data || c.rsp_zero !== (m_data == 0))
        $display("FAIL rnd_data op=%0d got %h/%b want %h", op, c.rsp_data,
                 c.rsp_zero, m_data);
      else passed++;
      checks++;
      if (ptr !== m_ptr || mem_addr !== m_ptr || err !== m_err)
        $display("FAIL rnd_ptr got %h/%h err=%b want %h err=%b", ptr, mem_addr,
                 err, m_ptr, m_err);
      else passed++;
      checks++;
      if (ram[m_ptr] !== ref_mem[m_ptr])
        $display("FAIL rnd_ram got %h want %h", ram[m_ptr], ref_mem[m_ptr]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc, due, accepted, rsps, elat;
    logic rdy;
    logic [2:0] op;
    logic [DATA_WIDTH-1:0] d;
    cyc = 0; due = -1; accepted = 0; rsps = 0;
    for (int i = 0; i < 306; i++) begin
      @(negedge clk);
      op = 3'($urandom);
      d  = DATA_WIDTH'($urandom);
      c.cmd_valid = (i < 300);
      c.cmd_op    = op;
      c.cmd_data  = d;
      rdy = c.cmd_ready && c.cmd_valid;
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        model_apply(op, d, elat);
        due = cyc + elat - 1;
        accepted++;
      end
      if (c.rsp_valid) begin
        rsps++;
        checks++;
        if (cyc !== due || c.rsp_data !== m_data || ptr !== m_ptr || err !== m_err)
          $display("FAIL b2b_rsp cyc=%0d got data=%h ptr=%h want due=%0d %h %h",
                   cyc, c.rsp_data, ptr, due, m_data, m_ptr);
        else passed++;
      end
    end
    c.cmd_valid = 1'b0;
    checks++;
    if (rsps !== accepted || accepted == 0)
      $display("FAIL b2b_count got %0d rsps want %0d", rsps, accepted);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_inc_wrap();
    test_move();
    test_bounds();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
